bm_result_bcd: RTL and testbench



---
 rtl/bm_pkg.sv | 21 ++
 rtl/bm_bcd_digit_adj.sv | 20 ++
 rtl/bm_result_bcd.sv | 148 ++++++++++++++
 tb/tb_bm_result_bcd.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bm_pkg.sv
// bm_pkg
// Shared definitions for the Booth multiplier result path.
//   PROD_W : product width, also the number of double-dabble iterations
//   N_DIG  : BCD digits produced (enough for 2^PROD_W - 1)
//   BCD_W  : packed BCD width, 4 bits per digit
//   CNT_W  : iteration-counter width
//   bm_state_t : converter FSM states (IDLE / CONV / DONE)
package bm_pkg;

  localparam int PROD_W = 16;
  localparam int N_DIG  = 5;
  localparam int BCD_W  = 4 * N_DIG;
  localparam int CNT_W  = $clog2(PROD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bm_state_t;

endpackage

// File: rtl/bm_bcd_digit_adj.sv
// bm_bcd_digit_adj
// One double-dabble digit correction: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
//   digit    in  4  working BCD digit before the shift
//   adjusted out 4  digit after the conditional +3 (4-bit wrap, no carry out)
module bm_bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // A digit >= 5 would become >= 10 after doubling; +3 turns that into a
  // clean carry into the next nibble.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/bm_result_bcd.sv
// bm_result_bcd
// Captures the Booth multiplier product on start and converts it to a sign
// flag plus packed BCD digits by iterative shift-and-add-3, taking exactly
// PROD_W clock cycles per conversion.
//   clk     in  1        system clock, rising edge
//   reset   in  1        synchronous, active-high; clears all state/outputs
//   start   in  1        request to convert product (ignored while busy)
//   product in  PROD_W   multiplier result, sampled on the accepting edge
//   busy    out 1        conversion in progress
//   valid   out 1        bcd/sign hold a completed result
//   sign    out 1        result is negative (signed build only, else 0)
//   bcd     out BCD_W    packed digits, most significant digit on top
// Build option: define BM_BCD_SIGNED_EN to treat product as two's
// complement; otherwise product is unsigned and sign is always 0.
module bm_result_bcd
  import bm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              valid,
  output logic              sign,
  output logic [BCD_W-1:0]  bcd
);

  bm_state_t state;
  bm_state_t next_state;

  logic [CNT_W-1:0]        iter_cnt;
  logic [PROD_W-1:0]       bin_work;
  logic [BCD_W-1:0]        bcd_work;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+PROD_W-1:0] shifted;
  logic                    sign_work;
  logic                    product_sign;
  logic [PROD_W-1:0]       magnitude;
  logic                    accept;
  logic                    last_iter;

`ifdef BM_BCD_SIGNED_EN
  // Two's complement input: the most negative value negates to itself,
  // which read as unsigned is exactly its magnitude.
  always_comb begin
    product_sign = product[PROD_W-1];
    magnitude    = product;
    if (product_sign) begin
      magnitude = ~product + 1'b1;
    end
  end
`else
  // Unsigned input: convert the raw bits, never negative.
  always_comb begin
    product_sign = 1'b0;
    magnitude    = product;
  end
`endif

  // One add-3 corrector per working digit.
  for (genvar i = 0; i < N_DIG; i++) begin : g_adj
    bm_bcd_digit_adj u_adj (
      .digit    (bcd_work[4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );
  end

  // Corrected digits and remaining binary bits shift left as one register.
  always_comb begin
    shifted = {bcd_adj, bin_work} << 1;
  end

  // A new request is taken only when no conversion is running.
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    last_iter = (state == CONV) && (iter_cnt == CNT_W'(PROD_W - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the status outputs decoded from the state.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    valid      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        valid = 1'b1;
        if (accept) begin
          next_state = CONV;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Working registers: loaded on accept, shifted once per CONV cycle.
  // start during CONV is deliberately dropped, not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_work  <= '0;
      bcd_work  <= '0;
      iter_cnt  <= '0;
      sign_work <= 1'b0;
    end else if (accept) begin
      bin_work  <= magnitude;
      bcd_work  <= '0;
      iter_cnt  <= '0;
      sign_work <= product_sign;
    end else if (state == CONV) begin
      {bcd_work, bin_work} <= shifted;
      iter_cnt             <= iter_cnt + 1'b1;
    end
  end

  // Result registers keep the previous answer until the final iteration,
  // so the display never shows a partial conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd  <= '0;
      sign <= 1'b0;
    end else if (last_iter) begin
      bcd  <= shifted[BCD_W+PROD_W-1 -: BCD_W];
      sign <= sign_work;
    end
  end

endmodule

// File: tb/tb_bm_result_bcd.sv
// tb_bm_result_bcd
// Self-checking bench for bm_result_bcd: a table of known conversions,
// randomized products against a decimal-arithmetic reference model, and
// hand-written sequences for start-while-busy, reset mid-conversion,
// reset-with-start and back-to-back starts.
// Build option: BM_BCD_SIGNED_EN selects the signed expectations.
module tb_bm_result_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] product;
  logic        busy;
  logic        valid;
  logic        sign;
  logic [19:0] bcd;

  int tests;
  int failures;
  logic [19:0] prevBcd;
  logic        prevSign;

  typedef struct {
    logic [15:0] product;
    logic [19:0] expBcd;
    logic        expSign;
  } vec_t;

  vec_t vectors[8];

  bm_result_bcd dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .product (product),
    .busy    (busy),
    .valid   (valid),
    .sign    (sign),
    .bcd     (bcd)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: magnitude by plain arithmetic, digits by / and %.
  function automatic void refModel(input logic [15:0] p, output logic [19:0] b,
                                   output logic s);
    int mag;
`ifdef BM_BCD_SIGNED_EN
    s   = p[15];
    mag = p[15] ? (65536 - int'(p)) : int'(p);
`else
    s   = 1'b0;
    mag = int'(p);
`endif
    b = '0;
    for (int k = 0; k < 5; k++) begin
      b[4*k +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) for busy to drop, counting negedges from startCount.
  task automatic waitDone(input int startCount, output int cycles);
    cycles = startCount;
    while (busy && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Issue one start at the current negedge and follow it to completion.
  task automatic applyStimulus(input logic [15:0] p, output int cycles);
    start   = 1'b1;
    product = p;
    @(negedge clk);
    start   = 1'b0;
    product = 16'($urandom);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("valid_dropped", 32'(valid), 32'd0);
    checkOutput("bcd_held_in_conv", 32'(bcd), 32'(prevBcd));
    checkOutput("sign_held_in_conv", 32'(sign), 32'(prevSign));
    waitDone(0, cycles);
  endtask

  task automatic checkResult(input string tag, input logic [19:0] expBcd,
                             input logic expSign, input int cycles);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd16);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
    checkOutput({tag, "_bcd"}, 32'(bcd), 32'(expBcd));
    checkOutput({tag, "_sign"}, 32'(sign), 32'(expSign));
    prevBcd  = expBcd;
    prevSign = expSign;
  endtask

  initial begin
    int          cycles;
    logic [15:0] p;
    logic [19:0] eb;
    logic        es;

    tests    = 0;
    failures = 0;
    prevBcd  = '0;
    prevSign = 1'b0;

`ifdef BM_BCD_SIGNED_EN
    vectors[0] = '{16'h0000, 20'h00000, 1'b0};
    vectors[1] = '{16'h3039, 20'h12345, 1'b0};
    vectors[2] = '{16'hFFF9, 20'h00007, 1'b1};
    vectors[3] = '{16'h8000, 20'h32768, 1'b1};
    vectors[4] = '{16'hFFFF, 20'h00001, 1'b1};
    vectors[5] = '{16'h0457, 20'h01111, 1'b0};
    vectors[6] = '{16'h7FFF, 20'h32767, 1'b0};
    vectors[7] = '{16'h0063, 20'h00099, 1'b0};
`else
    vectors[0] = '{16'h0000, 20'h00000, 1'b0};
    vectors[1] = '{16'h3039, 20'h12345, 1'b0};
    vectors[2] = '{16'hFFF9, 20'h65529, 1'b0};
    vectors[3] = '{16'h8000, 20'h32768, 1'b0};
    vectors[4] = '{16'hFFFF, 20'h65535, 1'b0};
    vectors[5] = '{16'h0457, 20'h01111, 1'b0};
    vectors[6] = '{16'h7FFF, 20'h32767, 1'b0};
    vectors[7] = '{16'h0063, 20'h00099, 1'b0};
`endif

    reset   = 1'b1;
    start   = 1'b0;
    product = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_sign", 32'(sign), 32'd0);
    checkOutput("reset_bcd", 32'(bcd), 32'd0);
    @(negedge clk);

    // Table vectors, issued back to back: each start lands in the first
    // DONE cycle of the previous conversion.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i].product, cycles);
      checkResult("table", vectors[i].expBcd, vectors[i].expSign, cycles);
    end

    // Start while busy: the second pulse must be ignored.
    start   = 1'b1;
    product = 16'h0064;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start   = 1'b1;
    product = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore_start_busy", 32'(busy), 32'd1);
    waitDone(5, cycles);
    checkResult("start_while_busy", 20'h00100, 1'b0, cycles);

    // Reset on the 8th busy cycle discards the partial result.
    @(negedge clk);
    start   = 1'b1;
    product = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_valid", 32'(valid), 32'd0);
    checkOutput("midreset_bcd", 32'(bcd), 32'd0);
    checkOutput("midreset_sign", 32'(sign), 32'd0);
    prevBcd  = '0;
    prevSign = 1'b0;
    @(negedge clk);
    checkOutput("midreset_stays_idle", 32'(busy), 32'd0);
    applyStimulus(16'h00FF, cycles);
    checkResult("after_reset", 20'h00255, 1'b0, cycles);

    // Reset and start together: reset wins, nothing is accepted.
    reset   = 1'b1;
    start   = 1'b1;
    product = 16'h0005;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", 32'(busy), 32'd0);
    checkOutput("rst_start_valid", 32'(valid), 32'd0);
    checkOutput("rst_start_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    checkOutput("rst_start_not_taken", 32'(busy), 32'd0);
    prevBcd  = '0;
    prevSign = 1'b0;

    // Random products with random idle gaps (gap 0 = back to back).
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      p = 16'($urandom);
      refModel(p, eb, es);
      applyStimulus(p, cycles);
      checkResult("random", eb, es, cycles);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
